// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC owner, in-order imem requester, small word FIFO towards decode.
// Latency: response word visible on Inst_Valid the cycle after its Rvalid; optional FETCH_STATS_EN adds fetch/flush counters.
// Backpressure: requests are credit-limited (occupancy + outstanding < DEPTH), so Inst_Ready low stalls fetch without loss.

module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
`ifdef FETCH_STATS_EN
    output logic [31:0] Fetch_Count,
    output logic [15:0] Flush_Count,
`endif
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Addr,
    output logic        Inst_Valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_Addr,
    output logic [31:0] Inst_PC4,
    input  logic        Inst_Ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] stale;
    logic [CW-1:0] occ;
    logic [CW-1:0] outst;
    logic [31:0]   tag_head;
    logic [63:0]   q_head;
    logic [31:0]   last_inst;
    logic [31:0]   last_addr;

    logic          issue;
    logic          rsp_take;
    logic          flush;
    logic          q_push;
    logic          q_pop;
    logic [CW-1:0] out_after;
    logic [CW-1:0] occ_nxt;
    logic [CW-1:0] out_nxt;
    logic          credit_ok;

    // Imem_Req is only ever high in RUN, so a grant here is always a real issue.
    assign issue    = Imem_Req & Imem_Gnt;
    assign rsp_take = (state == S_RUN) && Imem_Rvalid && (outst != '0);
    assign flush    = (state == S_RUN) && Redirect;
    assign q_push   = rsp_take && !Redirect;
    assign q_pop    = Inst_Valid && Inst_Ready && !Redirect;

    always_comb begin
        out_after = outst + CW'(issue) - CW'(rsp_take);
        occ_nxt   = Redirect ? '0 : occ + CW'(q_push) - CW'(q_pop);
        out_nxt   = flush ? '0 : ((state == S_RUN) ? out_after : outst);
        credit_ok = ({1'b0, occ_nxt} + {1'b0, out_nxt}) < (CW+1)'(DEPTH);
    end

    // Issue addresses of in-flight requests; its count is the outstanding total.
    ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clr      (flush),
        .push     (issue),
        .push_dat (pc),
        .pop      (rsp_take),
        .head_dat (tag_head),
        .count    (outst)
    );

    ifq_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clr      (Redirect),
        .push     (q_push),
        .push_dat ({tag_head, Imem_Rdata}),
        .pop      (q_pop),
        .head_dat (q_head),
        .count    (occ)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            stale    <= '0;
            Imem_Req <= 1'b0;
        end else begin
            if (Redirect)   pc <= Redirect_Addr & ~32'd3;
            else if (issue) pc <= pc + 32'd4;

            case (state)
                S_IDLE: begin
                    state    <= S_RUN;
                    Imem_Req <= credit_ok;
                end
                S_RUN: begin
                    if (Redirect && (out_after != '0)) begin
                        state    <= S_DRAIN;
                        stale    <= out_after;
                        Imem_Req <= 1'b0;
                    end else begin
                        Imem_Req <= credit_ok;
                    end
                end
                S_DRAIN: begin
                    if (Imem_Rvalid) begin
                        stale <= stale - 1'b1;
                        if (stale == CW'(1)) begin
                            state    <= S_RUN;
                            Imem_Req <= credit_ok;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    Imem_Req <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last presented head so outputs hold when the queue empties.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_inst <= '0;
            last_addr <= '0;
        end else if (Inst_Valid) begin
            last_inst <= q_head[31:0];
            last_addr <= q_head[63:32];
        end
    end

    assign Imem_Addr  = pc;
    assign Inst_Valid = (occ != '0);
    assign Inst       = Inst_Valid ? q_head[31:0]  : last_inst;
    assign Inst_Addr  = Inst_Valid ? q_head[63:32] : last_addr;
    assign Inst_PC4   = Inst_Addr + 32'd4;

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Fetch_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (q_push && (Fetch_Count != '1))  Fetch_Count <= Fetch_Count + 32'd1;
            if (Redirect && (Flush_Count != '1)) Flush_Count <= Flush_Count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases push expected fetch addresses,
// a memory model answers grants, and a monitor checks every word decode accepts.
`timescale 1ns/1ps

module tb_inst_fetch_queue;
    logic        Clk;
    logic        Rst_n;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Gnt;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic        Redirect;
    logic [31:0] Redirect_Addr;
    logic        Inst_Valid;
    logic [31:0] Inst;
    logic [31:0] Inst_Addr;
    logic [31:0] Inst_PC4;
    logic        Inst_Ready;
`ifdef FETCH_STATS_EN
    logic [31:0] Fetch_Count;
    logic [15:0] Flush_Count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        rsp_hold;
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    int          pop_cycles[$];
    logic [31:0] mon_exp;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
`ifdef FETCH_STATS_EN
        .Fetch_Count   (Fetch_Count),
        .Flush_Count   (Flush_Count),
`endif
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Imem_Gnt      (Imem_Gnt),
        .Imem_Rvalid   (Imem_Rvalid),
        .Imem_Rdata    (Imem_Rdata),
        .Redirect      (Redirect),
        .Redirect_Addr (Redirect_Addr),
        .Inst_Valid    (Inst_Valid),
        .Inst          (Inst),
        .Inst_Addr     (Inst_Addr),
        .Inst_PC4      (Inst_PC4),
        .Inst_Ready    (Inst_Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Grant exactly n requests, then drop Gnt; resumes at posedge+1.
    task automatic grant_n(input int n);
        int g = 0;
        int k = 0;
        Imem_Gnt = 1'b1;
        while (g < n && k < 100) begin
            @(negedge Clk);
            if (Imem_Req) g++;
            k++;
            @(posedge Clk); #1;
        end
        Imem_Gnt = 1'b0;
        chk("grant_count", g, n);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step(1);
            k++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    // Memory: a grant seen before edge N is answered in the cycle after edge N.
    initial begin
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = '0;
        forever begin
            @(negedge Clk);
            if (Imem_Req && Imem_Gnt) pend.push_back(Imem_Addr);
            @(posedge Clk); #2;
            if (!rsp_hold && pend.size() > 0) begin
                Imem_Rvalid = 1'b1;
                Imem_Rdata  = mem_word(pend.pop_front());
            end else begin
                Imem_Rvalid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (Rst_n && Inst_Valid && Inst_Ready) begin
                pop_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got addr %h, required no word", Inst_Addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("pop_addr", Inst_Addr, mon_exp);
                    chk("pop_inst", Inst, mem_word(mon_exp));
                    chk("pop_pc4", Inst_PC4, mon_exp + 32'd4);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; Imem_Gnt = 1'b0; Redirect = 1'b0; Redirect_Addr = '0;
        Inst_Ready = 1'b0; rsp_hold = 1'b0;
        step(3);
        @(negedge Clk);
        chk("rst_req", Imem_Req, 0);
        chk("rst_addr", Imem_Addr, 32'h0);
        chk("rst_valid", Inst_Valid, 0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_inst_addr", Inst_Addr, 32'h0);
        chk("rst_pc4", Inst_PC4, 32'h4);
        @(posedge Clk); #1;

        // Streaming: eight words, one per cycle once filled
        Rst_n = 1'b1; Inst_Ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        pop_cycles.delete();
        grant_n(8);
        wait_drain("p1_drain");
        chk("p1_pops", pop_cycles.size(), 8);
        if (pop_cycles.size() >= 8) chk("p1_span", pop_cycles[7] - pop_cycles[0], 7);

        // Stalled decode: credit limit stops fetch at DEPTH words
        Inst_Ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + 32'(i * 4));
        begin
            int g = 0;
            Imem_Gnt = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge Clk);
                if (Imem_Req && Imem_Gnt) g++;
            end
            @(posedge Clk); #1;
            Imem_Gnt = 1'b0;
            chk("p2_grants", g, 4);
        end
        @(negedge Clk);
        chk("p2_req_full", Imem_Req, 0);
        chk("p2_next_addr", Imem_Addr, 32'h30);
        chk("p2_head_valid", Inst_Valid, 1);
        chk("p2_head_addr", Inst_Addr, 32'h20);
        @(posedge Clk); #1;
        Inst_Ready = 1'b1;
        wait_drain("p2_drain");
        @(negedge Clk);
        chk("p2_req_resume", Imem_Req, 1);
        chk("p2_addr_stable", Imem_Addr, 32'h30);
        @(posedge Clk); #1;

        // Redirect with two outstanding: both responses dropped
        rsp_hold = 1'b1;
        grant_n(2);
        Redirect = 1'b1; Redirect_Addr = 32'h103;
        step(1);
        Redirect = 1'b0;
        @(negedge Clk);
        chk("p3_drain_req", Imem_Req, 0);
        chk("p3_target", Imem_Addr, 32'h100);
        chk("p3_drain_valid", Inst_Valid, 0);
        @(posedge Clk); #1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        rsp_hold = 1'b0;
        grant_n(3);
        wait_drain("p3_drain");

        // Redirect coinciding with a pop and an Rvalid
        Inst_Ready = 1'b0;
        grant_n(2);
        step(4);
        rsp_hold = 1'b1;
        grant_n(1);
        exp_q.push_back(32'h10C);
        Inst_Ready = 1'b1; Redirect = 1'b1; Redirect_Addr = 32'hFFFF_FFFC; rsp_hold = 1'b0;
        step(1);
        Redirect = 1'b0; Inst_Ready = 1'b0;
        @(negedge Clk);
        chk("p4_empty", Inst_Valid, 0);
        chk("p4_hold_addr", Inst_Addr, 32'h10C);
        chk("p4_req", Imem_Req, 1);
        chk("p4_target", Imem_Addr, 32'hFFFF_FFFC);
        @(posedge Clk); #1;
        chk("p4_no_repeat", exp_q.size(), 0);

        // Address wrap at the top of the space
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        Inst_Ready = 1'b1;
        grant_n(2);
        wait_drain("p5_drain");

        // Reset mid-operation: late responses are ignored
        Inst_Ready = 1'b0; rsp_hold = 1'b1;
        grant_n(2);
        Rst_n = 1'b0;
        step(2);
        @(negedge Clk);
        chk("p6_rst_req", Imem_Req, 0);
        chk("p6_rst_addr", Imem_Addr, 32'h0);
`ifdef FETCH_STATS_EN
        chk("p6_fetch_cnt_rst", Fetch_Count, 32'h0);
        chk("p6_flush_cnt_rst", {16'h0, Flush_Count}, 32'h0);
`endif
        @(posedge Clk); #1;
        Rst_n = 1'b1; rsp_hold = 1'b0;
        step(5);
        @(negedge Clk);
        chk("p6_ignored_valid", Inst_Valid, 0);
        chk("p6_inst_addr", Inst_Addr, 32'h0);
        chk("p6_pc4", Inst_PC4, 32'h4);
        chk("p6_req", Imem_Req, 1);
        @(posedge Clk); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        Inst_Ready = 1'b1;
        grant_n(2);
        wait_drain("p6_drain");

`ifdef FETCH_STATS_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h8 + 32'(i * 4));
        grant_n(8);
        wait_drain("p7_drain");
        for (int i = 0; i < 3; i++) begin
            Redirect = 1'b1; Redirect_Addr = 32'h200;
            step(1);
            Redirect = 1'b0;
            step(1);
        end
        @(negedge Clk);
        chk("p7_fetch_cnt", Fetch_Count, 32'd10);
        chk("p7_flush_cnt", {16'h0, Flush_Count}, 32'd3);
        @(posedge Clk); #1;
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
